control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Microcode sequencer that drives the control lines of the program counter and other datapath blocks.
//  Per instruction it steps T0..T(STEPS-1). Each step emits a control word decoded from step, opcode and
//  flags: fetch first, then execute. It sits beside the instruction register on the shared 4-bit bus.
// PARAMETERS
//  STEPS       5  steps per instruction cycle; legal range 5..8; steps above T4 are always empty.
//  SKIP_EMPTY  1  1: an empty execute step ends the instruction early; 0: every instruction takes STEPS cycles.
// PORTS
//  clk               in   1  system clock; all state changes on its rising edge.
//  clear_n           in   1  asynchronous, active-low reset.
//  opcode            in   4  instruction register upper nibble; stable from T2 onward.
//  flag_carry        in   1  latched carry flag.
//  flag_zero         in   1  latched zero flag.
//  pc_enable         out  1  PC count enable (active-high).
//  pc_jump_n         out  1  PC parallel load from bus.
//  pc_bus_enable_n   out  1  PC drives bus.
//  mar_load_n        out  1  memory address register load.
//  ram_bus_enable_n  out  1  RAM drives bus.
//  ram_write_n       out  1  RAM write strobe.
//  ir_load_n         out  1  instruction register load.
//  ir_bus_enable_n   out  1  IR operand nibble drives bus.
//  a_load_n          out  1  A register load.
//  a_bus_enable_n    out  1  A register drives bus.
//  b_load_n          out  1  B register load.
//  alu_bus_enable_n  out  1  ALU result drives bus.
//  alu_subtract      out  1  ALU subtract select (active-high).
//  flags_load_n      out  1  flags register load.
//  out_load_n        out  1  output register load.
//  halt              out  1  clock-stop request, sticky.
//  step              out  3  current step index, for debug/display.
// BEHAVIOUR
//  Names ending _n are active-low; inactive level is 1. pc_enable, alu_subtract and halt are inactive at 0.
//  Reset (clear_n=0) is asynchronous and immediate:
//   - step=0 and halt=0.
//   - Every control output is forced inactive while clear_n is low.
//   - The first edge after release samples the T0 word.
//  Control word is combinational from {step, opcode, flags, halted}; it is consumed by the datapath on the next edge.
//  Fetch steps:
//   - T0: pc_bus_enable_n=0, mar_load_n=0.
//   - T1: ram_bus_enable_n=0, ir_load_n=0, pc_enable=1.
//  Execute steps, all "operand" = ir_bus_enable_n=0:
//   - 0 NOP: none.
//   - 1 LDA: T2 operand+mar_load; T3 ram_bus+a_load.
//   - 2 ADD: T2 operand+mar_load; T3 ram_bus+b_load; T4 alu_bus+a_load+flags_load.
//   - 3 SUB: as ADD, plus alu_subtract=1 in T4.
//   - 4 STA: T2 operand+mar_load; T3 a_bus+ram_write.
//   - 5 LDI: T2 operand+a_load.
//   - 6 JMP: T2 operand+pc_jump.
//   - 7 JC: T2 operand+pc_jump only if flag_carry=1; otherwise T2 is empty.
//   - 8 JZ: same as JC, gated on flag_zero.
//   - E OUT: T2 a_bus+out_load.
//   - F HLT: T2 halt=1.
//   - 9-D: treated as NOP.
//  Flags are sampled combinationally during T2. A flag change during T2 changes the word within the same step.
//  Next-step rule, evaluated at each rising edge:
//   - step==STEPS-1 -> 0.
//   - SKIP_EMPTY=1 and step>=2 and (word(step) empty or word(step+1) empty) -> 0.
//   - otherwise step+1.
//  Cycle counts with SKIP_EMPTY=1: NOP/JMP/LDI/OUT/not-taken JC 3, LDA/STA 4, ADD/SUB 5.
//  T0 and T1 are never skipped. At most one bus driver is enabled in any step (invariant, asserted in sim).
//  Halt:
//   - The edge ending HLT T2 sets the halted register; step then freezes at 2.
//   - While halted: halt=1 and all other controls inactive.
//   - Halt is exited only by clear_n=0.
// TESTING
//  1 Reset mid ADD T3 (clear_n=0 between edges) -> all controls inactive same cycle; step=0. After release: T0 word (pc_bus_enable_n=0, mar_load_n=0).
//  2 opcode=1 (LDA), SKIP_EMPTY=1 -> step trace 0,1,2,3,0. T3 word: ram_bus_enable_n=0 and a_load_n=0 only.
//  3 opcode=3 (SUB) -> step trace 0..4. T4: alu_bus_enable_n=0, a_load_n=0, flags_load_n=0, alu_subtract=1. Same with opcode=2 -> alu_subtract=0.
//  4 opcode=7 (JC):
//     - flag_carry=0 -> trace 0,1,2,0 with pc_jump_n=1 throughout.
//     - flag_carry=1 -> pc_jump_n=0 and ir_bus_enable_n=0 in T2.
//  5 opcode=F (HLT) -> halt=1 from T2 on; step stays 2 for 10 clocks with all other outputs inactive. clear_n pulse -> halt=0, step=0.
//  6 SKIP_EMPTY=0, opcode=0 (NOP) -> trace 0,1,2,3,4,0. Random opcode/flag soak: never two bus drivers enabled at once.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the microcode sequencer and the datapath it steers.
// Instruction/flag inputs flow toward the sequencer; control strobes flow back out.
interface control_sequencer_if;
  logic [3:0] opcode;
  logic       flag_carry;
  logic       flag_zero;

  logic       pc_enable;
  logic       pc_jump_n;
  logic       pc_bus_enable_n;
  logic       mar_load_n;
  logic       ram_bus_enable_n;
  logic       ram_write_n;
  logic       ir_load_n;
  logic       ir_bus_enable_n;
  logic       a_load_n;
  logic       a_bus_enable_n;
  logic       b_load_n;
  logic       alu_bus_enable_n;
  logic       alu_subtract;
  logic       flags_load_n;
  logic       out_load_n;
  logic       halt;
  logic [2:0] step;

  modport master (
    input  opcode, flag_carry, flag_zero,
    output pc_enable, pc_jump_n, pc_bus_enable_n, mar_load_n,
           ram_bus_enable_n, ram_write_n, ir_load_n, ir_bus_enable_n,
           a_load_n, a_bus_enable_n, b_load_n, alu_bus_enable_n,
           alu_subtract, flags_load_n, out_load_n, halt, step
  );

  modport slave (
    output opcode, flag_carry, flag_zero,
    input  pc_enable, pc_jump_n, pc_bus_enable_n, mar_load_n,
           ram_bus_enable_n, ram_write_n, ir_load_n, ir_bus_enable_n,
           a_load_n, a_bus_enable_n, b_load_n, alu_bus_enable_n,
           alu_subtract, flags_load_n, out_load_n, halt, step
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer: walks T0..T(STEPS-1) per instruction and decodes a control word
// from {step, opcode, flags, halted}; fetch in T0/T1, execute from T2.
module control_sequencer #(
  parameter int STEPS      = 5,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic                clk,
  input  logic                clear_n,
  control_sequencer_if.master ctl
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word in active-high form; polarity is applied only at the ports.
  typedef struct packed {
    logic pc_enable;
    logic pc_jump;
    logic pc_bus;
    logic mar_load;
    logic ram_bus;
    logic ram_write;
    logic ir_load;
    logic ir_bus;
    logic a_load;
    logic a_bus;
    logic b_load;
    logic alu_bus;
    logic alu_subtract;
    logic flags_load;
    logic out_load;
    logic halt;
  } ctrl_t;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  ctrl_t      word_raw, word_next, word_out;

  function automatic ctrl_t decode(input logic [2:0] s, input logic [3:0] op,
                                   input logic carry, input logic zero);
    ctrl_t w;
    w = '0;
    case (s)
      3'd0: begin
        w.pc_bus   = 1'b1;
        w.mar_load = 1'b1;
      end
      3'd1: begin
        w.ram_bus   = 1'b1;
        w.ir_load   = 1'b1;
        w.pc_enable = 1'b1;
      end
      3'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w.ir_bus   = 1'b1;
            w.mar_load = 1'b1;
          end
          OP_LDI: begin
            w.ir_bus = 1'b1;
            w.a_load = 1'b1;
          end
          OP_JMP: begin
            w.ir_bus  = 1'b1;
            w.pc_jump = 1'b1;
          end
          OP_JC: begin
            w.ir_bus  = carry;
            w.pc_jump = carry;
          end
          OP_JZ: begin
            w.ir_bus  = zero;
            w.pc_jump = zero;
          end
          OP_OUT: begin
            w.a_bus    = 1'b1;
            w.out_load = 1'b1;
          end
          OP_HLT: w.halt = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA: begin
            w.ram_bus = 1'b1;
            w.a_load  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w.ram_bus = 1'b1;
            w.b_load  = 1'b1;
          end
          OP_STA: begin
            w.a_bus     = 1'b1;
            w.ram_write = 1'b1;
          end
          default: ;
        endcase
      end
      3'd4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          w.alu_bus      = 1'b1;
          w.a_load       = 1'b1;
          w.flags_load   = 1'b1;
          w.alu_subtract = (op == OP_SUB);
        end
      end
      // T5..T7 never carry work, whatever STEPS is.
      default: ;
    endcase
    return w;
  endfunction

  assign word_raw  = decode(step_q, ctl.opcode, ctl.flag_carry, ctl.flag_zero);
  assign word_next = decode(step_q + 3'd1, ctl.opcode, ctl.flag_carry, ctl.flag_zero);

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // holding its old value and no latch is inferred.
  always_comb begin
    step_d   = step_q + 3'd1;
    halted_d = halted_q | word_raw.halt;
    if (halted_q || word_raw.halt) begin
      step_d = step_q;
    end else if (step_q == LAST_STEP) begin
      step_d = '0;
    end else if (SKIP_EMPTY && step_q >= 3'd2 &&
                 (word_raw == '0 || word_next == '0)) begin
      // Lookahead on step+1 lets the last useful step wrap straight to T0.
      step_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; only the two state registers need a reset.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Reset gates the word combinationally so controls go quiet the moment clear_n drops.
  always_comb begin
    word_out = word_raw;
    if (!clear_n) begin
      word_out = '0;
    end else if (halted_q) begin
      word_out      = '0;
      word_out.halt = 1'b1;
    end
  end

  assign ctl.pc_enable        =  word_out.pc_enable;
  assign ctl.pc_jump_n        = ~word_out.pc_jump;
  assign ctl.pc_bus_enable_n  = ~word_out.pc_bus;
  assign ctl.mar_load_n       = ~word_out.mar_load;
  assign ctl.ram_bus_enable_n = ~word_out.ram_bus;
  assign ctl.ram_write_n      = ~word_out.ram_write;
  assign ctl.ir_load_n        = ~word_out.ir_load;
  assign ctl.ir_bus_enable_n  = ~word_out.ir_bus;
  assign ctl.a_load_n         = ~word_out.a_load;
  assign ctl.a_bus_enable_n   = ~word_out.a_bus;
  assign ctl.b_load_n         = ~word_out.b_load;
  assign ctl.alu_bus_enable_n = ~word_out.alu_bus;
  assign ctl.alu_subtract     =  word_out.alu_subtract;
  assign ctl.flags_load_n     = ~word_out.flags_load;
  assign ctl.out_load_n       = ~word_out.out_load;
  assign ctl.halt             =  word_out.halt;
  assign ctl.step             =  step_q;

  logic [4:0] bus_drivers;
  assign bus_drivers = {word_out.pc_bus, word_out.ram_bus, word_out.ir_bus,
                        word_out.a_bus, word_out.alu_bus};

  // The shared 4-bit bus must never see two drivers in the same step.
  assert property (@(posedge clk) disable iff (!clear_n) $onehot0(bus_drivers));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one skipping (SKIP_EMPTY=1) and one
// full-length (SKIP_EMPTY=0) instance share clock, reset, opcode and flags.
module tb_control_sequencer;

  // Bit positions of the packed control vector; XOR into IDLE activates a signal.
  localparam logic [15:0] PC_EN   = 16'h8000;
  localparam logic [15:0] PC_JMP  = 16'h4000;
  localparam logic [15:0] PC_BUS  = 16'h2000;
  localparam logic [15:0] MAR     = 16'h1000;
  localparam logic [15:0] RAM_BUS = 16'h0800;
  localparam logic [15:0] RAM_WR  = 16'h0400;
  localparam logic [15:0] IR_LD   = 16'h0200;
  localparam logic [15:0] IR_BUS  = 16'h0100;
  localparam logic [15:0] A_LD    = 16'h0080;
  localparam logic [15:0] A_BUS   = 16'h0040;
  localparam logic [15:0] B_LD    = 16'h0020;
  localparam logic [15:0] ALU_BUS = 16'h0010;
  localparam logic [15:0] ALU_SUB = 16'h0008;
  localparam logic [15:0] FL_LD   = 16'h0004;
  localparam logic [15:0] OUT_LD  = 16'h0002;
  localparam logic [15:0] HALT    = 16'h0001;

  localparam logic [15:0] IDLE    = 16'h7FF6;
  localparam logic [15:0] W_T0    = IDLE ^ PC_BUS ^ MAR;
  localparam logic [15:0] W_T1    = IDLE ^ RAM_BUS ^ IR_LD ^ PC_EN;
  localparam logic [15:0] W_HALT  = IDLE ^ HALT;
  localparam logic [15:0] BUS_DRV = PC_BUS | RAM_BUS | IR_BUS | A_BUS | ALU_BUS;

  logic       clk;
  logic       clear_n;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;
  int         n_vec;
  int         n_err;

  control_sequencer_if if_s ();
  control_sequencer_if if_f ();

  assign if_s.opcode     = opcode;
  assign if_s.flag_carry = carry;
  assign if_s.flag_zero  = zero;
  assign if_f.opcode     = opcode;
  assign if_f.flag_carry = carry;
  assign if_f.flag_zero  = zero;

  control_sequencer #(.STEPS(5), .SKIP_EMPTY(1'b1)) u_skip (
    .clk     (clk),
    .clear_n (clear_n),
    .ctl     (if_s)
  );

  control_sequencer #(.STEPS(5), .SKIP_EMPTY(1'b0)) u_full (
    .clk     (clk),
    .clear_n (clear_n),
    .ctl     (if_f)
  );

  logic [15:0] ctrl_s, ctrl_f;
  assign ctrl_s = {if_s.pc_enable, if_s.pc_jump_n, if_s.pc_bus_enable_n, if_s.mar_load_n,
                   if_s.ram_bus_enable_n, if_s.ram_write_n, if_s.ir_load_n, if_s.ir_bus_enable_n,
                   if_s.a_load_n, if_s.a_bus_enable_n, if_s.b_load_n, if_s.alu_bus_enable_n,
                   if_s.alu_subtract, if_s.flags_load_n, if_s.out_load_n, if_s.halt};
  assign ctrl_f = {if_f.pc_enable, if_f.pc_jump_n, if_f.pc_bus_enable_n, if_f.mar_load_n,
                   if_f.ram_bus_enable_n, if_f.ram_write_n, if_f.ir_load_n, if_f.ir_bus_enable_n,
                   if_f.a_load_n, if_f.a_bus_enable_n, if_f.b_load_n, if_f.alu_bus_enable_n,
                   if_f.alu_subtract, if_f.flags_load_n, if_f.out_load_n, if_f.halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples 1 ns after a falling edge, well clear of the rising edge.
  task automatic look(input string tag, input bit full, input logic [2:0] s,
                      input logic [15:0] w);
    logic [2:0]  so;
    logic [15:0] wo;
    #1;
    so = full ? if_f.step : if_s.step;
    wo = full ? ctrl_f : ctrl_s;
    n_vec++;
    assert (so === s) else begin
      n_err++;
      $error("FAIL %s step: observed %0d expected %0d", tag, so, s);
    end
    n_vec++;
    assert (wo === w) else begin
      n_err++;
      $error("FAIL %s word: observed %h expected %h", tag, wo, w);
    end
  endtask

  task automatic step_expect(input string tag, input bit full, input logic [2:0] s,
                             input logic [15:0] w);
    look(tag, full, s, w);
    @(negedge clk);
  endtask

  task automatic check_bus(input string tag, input logic [15:0] w);
    int drivers;
    drivers = $countones(~w & BUS_DRV);
    n_vec++;
    assert (drivers <= 1) else begin
      n_err++;
      $error("FAIL %s: observed %0d bus drivers expected at most 1", tag, drivers);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    clear_n = 1'b0;
    opcode  = 4'h1;
    carry   = 1'b0;
    zero    = 1'b0;
    repeat (2) @(negedge clk);
    look("reset_skip", 1'b0, 3'd0, IDLE);
    look("reset_full", 1'b1, 3'd0, IDLE);
    clear_n = 1'b1;

    // LDA: 0,1,2,3,0
    step_expect("lda_t0", 1'b0, 3'd0, W_T0);
    step_expect("lda_t1", 1'b0, 3'd1, W_T1);
    step_expect("lda_t2", 1'b0, 3'd2, IDLE ^ IR_BUS ^ MAR);
    step_expect("lda_t3", 1'b0, 3'd3, IDLE ^ RAM_BUS ^ A_LD);

    // SUB then ADD: full five steps, subtract only on SUB
    opcode = 4'h3;
    step_expect("sub_t0", 1'b0, 3'd0, W_T0);
    step_expect("sub_t1", 1'b0, 3'd1, W_T1);
    step_expect("sub_t2", 1'b0, 3'd2, IDLE ^ IR_BUS ^ MAR);
    step_expect("sub_t3", 1'b0, 3'd3, IDLE ^ RAM_BUS ^ B_LD);
    step_expect("sub_t4", 1'b0, 3'd4, IDLE ^ ALU_BUS ^ A_LD ^ FL_LD ^ ALU_SUB);
    opcode = 4'h2;
    step_expect("add_t0", 1'b0, 3'd0, W_T0);
    step_expect("add_t1", 1'b0, 3'd1, W_T1);
    step_expect("add_t2", 1'b0, 3'd2, IDLE ^ IR_BUS ^ MAR);
    step_expect("add_t3", 1'b0, 3'd3, IDLE ^ RAM_BUS ^ B_LD);
    step_expect("add_t4", 1'b0, 3'd4, IDLE ^ ALU_BUS ^ A_LD ^ FL_LD);

    // Reset lands in the middle of ADD T3
    step_expect("add2_t0", 1'b0, 3'd0, W_T0);
    step_expect("add2_t1", 1'b0, 3'd1, W_T1);
    step_expect("add2_t2", 1'b0, 3'd2, IDLE ^ IR_BUS ^ MAR);
    look("add2_t3", 1'b0, 3'd3, IDLE ^ RAM_BUS ^ B_LD);
    clear_n = 1'b0;
    look("midreset_now", 1'b0, 3'd0, IDLE);
    @(negedge clk);
    look("midreset_held", 1'b0, 3'd0, IDLE);
    clear_n = 1'b1;

    // JC not taken, then taken
    opcode = 4'h7;
    step_expect("jc0_t0", 1'b0, 3'd0, W_T0);
    step_expect("jc0_t1", 1'b0, 3'd1, W_T1);
    step_expect("jc0_t2", 1'b0, 3'd2, IDLE);
    carry = 1'b1;
    step_expect("jc1_t0", 1'b0, 3'd0, W_T0);
    step_expect("jc1_t1", 1'b0, 3'd1, W_T1);
    step_expect("jc1_t2", 1'b0, 3'd2, IDLE ^ IR_BUS ^ PC_JMP);

    // JZ: zero flag rises during T2, word follows within the step
    carry  = 1'b0;
    opcode = 4'h8;
    step_expect("jz_t0", 1'b0, 3'd0, W_T0);
    step_expect("jz_t1", 1'b0, 3'd1, W_T1);
    look("jz_t2_flag0", 1'b0, 3'd2, IDLE);
    zero = 1'b1;
    step_expect("jz_t2_flag1", 1'b0, 3'd2, IDLE ^ IR_BUS ^ PC_JMP);
    zero = 1'b0;

    // LDI, STA, OUT, and an undefined opcode
    opcode = 4'h5;
    step_expect("ldi_t0", 1'b0, 3'd0, W_T0);
    step_expect("ldi_t1", 1'b0, 3'd1, W_T1);
    step_expect("ldi_t2", 1'b0, 3'd2, IDLE ^ IR_BUS ^ A_LD);
    opcode = 4'h4;
    step_expect("sta_t0", 1'b0, 3'd0, W_T0);
    step_expect("sta_t1", 1'b0, 3'd1, W_T1);
    step_expect("sta_t2", 1'b0, 3'd2, IDLE ^ IR_BUS ^ MAR);
    step_expect("sta_t3", 1'b0, 3'd3, IDLE ^ A_BUS ^ RAM_WR);
    opcode = 4'hE;
    step_expect("out_t0", 1'b0, 3'd0, W_T0);
    step_expect("out_t1", 1'b0, 3'd1, W_T1);
    step_expect("out_t2", 1'b0, 3'd2, IDLE ^ A_BUS ^ OUT_LD);
    opcode = 4'hA;
    step_expect("opa_t0", 1'b0, 3'd0, W_T0);
    step_expect("opa_t1", 1'b0, 3'd1, W_T1);
    step_expect("opa_t2", 1'b0, 3'd2, IDLE);

    // HLT: frozen at T2 regardless of later opcode/flags, until clear_n
    opcode = 4'hF;
    step_expect("hlt_t0", 1'b0, 3'd0, W_T0);
    step_expect("hlt_t1", 1'b0, 3'd1, W_T1);
    step_expect("hlt_t2", 1'b0, 3'd2, W_HALT);
    opcode = 4'h2;
    carry  = 1'b1;
    zero   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_expect($sformatf("halted_%0d", i), 1'b0, 3'd2, W_HALT);
    end
    clear_n = 1'b0;
    look("halt_clear", 1'b0, 3'd0, IDLE);
    @(negedge clk);
    clear_n = 1'b1;
    opcode  = 4'h0;
    carry   = 1'b0;
    zero    = 1'b0;

    // SKIP_EMPTY=0 instance runs NOP for all five steps
    step_expect("full_nop_t0", 1'b1, 3'd0, W_T0);
    step_expect("full_nop_t1", 1'b1, 3'd1, W_T1);
    step_expect("full_nop_t2", 1'b1, 3'd2, IDLE);
    step_expect("full_nop_t3", 1'b1, 3'd3, IDLE);
    step_expect("full_nop_t4", 1'b1, 3'd4, IDLE);
    look("full_nop_wrap", 1'b1, 3'd0, W_T0);

    // Random opcode/flag soak (HLT excluded) on both instances
    for (int i = 0; i < 300; i++) begin
      if (if_s.step == 3'd0) opcode = 4'($urandom_range(0, 14));
      carry = 1'($urandom);
      zero  = 1'($urandom);
      #1;
      check_bus("soak_bus_skip", ctrl_s);
      check_bus("soak_bus_full", ctrl_f);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
